// File: rtl/pwm_duty_modulator_pkg.sv
// pwm_duty_modulator_pkg: shared types and constants for the PWM duty modulator.
package pwm_duty_modulator_pkg;
  localparam int DUTY_W       = 6;
  localparam int PERIOD_TICKS = 2 ** DUTY_W;
  typedef logic [DUTY_W-1:0] duty_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
endpackage

// File: rtl/pwm_duty_modulator_enable_synchroniser.sv
// pwm_duty_modulator_enable_synchroniser: 2-flop synchroniser for asynchronous switch inputs.
module pwm_duty_modulator_enable_synchroniser (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/pwm_duty_modulator.sv
// pwm_duty_modulator: glitch-free PWM from a period-sampled duty word.
// Define PWM_COMPLEMENT_EN to add the dead-time separated complementary output PWM_Out_N.
module pwm_duty_modulator
  import pwm_duty_modulator_pkg::*;
#(
  parameter int CLK_DIV = 50
`ifdef PWM_COMPLEMENT_EN
  , parameter int DEAD_TICKS = 2
`endif
) (
  input  logic  sysclk,
  input  logic  Reset_n,
  input  logic  Enable_SW_0,
  input  duty_t Duty_In,
  output logic  PWM_Out,
`ifdef PWM_COMPLEMENT_EN
  output logic  PWM_Out_N,
`endif
  output logic  Period_Start,
  output duty_t Duty_Active,
  output logic  Busy
);
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  state_e state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  duty_t tick_q, tick_d, duty_q, duty_d;
  logic pwm_q, pwm_d, start_q, start_d, en_s, pre_wrap, pend, idle;
  pwm_duty_modulator_enable_synchroniser u_en_sync (
    .clk_i  (sysclk),
    .rst_ni (Reset_n),
    .d_i    (Enable_SW_0),
    .q_o    (en_s)
  );
  always_ff @(posedge sysclk or negedge Reset_n)
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  // A dropped enable only drains: the period in flight always runs to its end.
  always_comb begin
    idle    = (state_q == IDLE);
    state_d = en_s ? RUN : (idle || pend) ? IDLE : DRAIN;
  end
  always_comb begin
    start_d = en_s && (idle || pend);
    duty_d  = start_d ? Duty_In : duty_q;
    pwm_d   = (state_d != IDLE) && (tick_d < duty_d);
  end
  always_comb begin
    pre_wrap = (pre_q == PRE_W'(CLK_DIV - 1));
    pend     = pre_wrap && (tick_q == duty_t'(PERIOD_TICKS - 1));
    pre_d    = (idle || pre_wrap) ? '0 : pre_q + 1'b1;
    tick_d   = idle ? '0 : pre_wrap ? tick_q + 1'b1 : tick_q;
  end
  always_ff @(posedge sysclk or negedge Reset_n)
    if (!Reset_n) begin
      pre_q   <= '0;
      tick_q  <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      start_q <= start_d;
    end
`ifdef PWM_COMPLEMENT_EN
  // 7-bit compare so duty+dead-time cannot wrap back into the period.
  logic pwmn_q, pwmn_d;
  always_comb
    pwmn_d = (state_d != IDLE)
          && ({1'b0, tick_d} >= ({1'b0, duty_d} + 7'(DEAD_TICKS)))
          && ({1'b0, tick_d} <= 7'(PERIOD_TICKS - 1 - DEAD_TICKS));
  always_ff @(posedge sysclk or negedge Reset_n)
    if (!Reset_n) pwmn_q <= 1'b0;
    else          pwmn_q <= pwmn_d;
  assign PWM_Out_N = pwmn_q;
`endif
  assign PWM_Out      = pwm_q;
  assign Period_Start = start_q;
  assign Duty_Active  = duty_q;
  assign Busy         = (state_q != IDLE);
endmodule

// File: tb/tb_pwm_duty_modulator.sv
// tb_pwm_duty_modulator: directed self-checking bench, CLK_DIV=4 (256-cycle period).
module tb_pwm_duty_modulator;
  logic       sysclk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Enable_SW_0 = 1'b0;
  logic [5:0] Duty_In = 6'd0;
  logic       PWM_Out, Period_Start, Busy;
  logic [5:0] Duty_Active;
  int n_checks = 0;
  int n_errors = 0;
`ifdef PWM_COMPLEMENT_EN
  logic PWM_Out_N;
`endif
  pwm_duty_modulator #(.CLK_DIV(4)) dut (
    .sysclk       (sysclk),
    .Reset_n      (Reset_n),
    .Enable_SW_0  (Enable_SW_0),
    .Duty_In      (Duty_In),
    .PWM_Out      (PWM_Out),
`ifdef PWM_COMPLEMENT_EN
    .PWM_Out_N    (PWM_Out_N),
`endif
    .Period_Start (Period_Start),
    .Duty_Active  (Duty_Active),
    .Busy         (Busy)
  );
  always #5 sysclk = ~sysclk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_start(input string tag);
    int cnt = 0;
    while (cnt < 20 && !Period_Start) begin
      @(negedge sysclk);
      cnt++;
    end
    check(tag, cnt, 3);
  endtask
  // Runs one full period from a Period_Start sample, optionally changing inputs at given indices.
  task automatic period(input int chg_at, input logic [5:0] nd, input int off_at, input int on_at,
                        output int hi, output int hn, output int ov, output int ps);
    hi = 0; hn = 0; ov = 0; ps = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == chg_at) Duty_In = nd;
      if (i == off_at) Enable_SW_0 = 1'b0;
      if (i == on_at)  Enable_SW_0 = 1'b1;
      hi += int'(PWM_Out);
      ps += int'(Period_Start);
`ifdef PWM_COMPLEMENT_EN
      hn += int'(PWM_Out_N);
      ov += int'(PWM_Out & PWM_Out_N);
`endif
      @(negedge sysclk);
    end
  endtask
  initial begin
    int hi, hn, ov, ps;
    repeat (3) @(negedge sysclk);
    check("rst_pwm", int'(PWM_Out), 0);
    check("rst_ps", int'(Period_Start), 0);
    check("rst_duty", int'(Duty_Active), 0);
    check("rst_busy", int'(Busy), 0);
    Reset_n = 1'b1;
    @(negedge sysclk);
    Duty_In = 6'd16;
    Enable_SW_0 = 1'b1;
    wait_start("start_latency");
    check("start_duty", int'(Duty_Active), 16);
    check("start_busy", int'(Busy), 1);
    check("start_pwm", int'(PWM_Out), 1);
    period(-1, 6'd0, -1, -1, hi, hn, ov, ps);
    check("p16_high", hi, 64);
    check("p16_ps", ps, 1);
    check("p16_next_ps", int'(Period_Start), 1);
    period(100, 6'd48, -1, -1, hi, hn, ov, ps);
    check("midchg_high", hi, 64);
    check("p48_duty", int'(Duty_Active), 48);
    period(10, 6'd0, -1, -1, hi, hn, ov, ps);
    check("p48_high", hi, 192);
    check("p0_duty", int'(Duty_Active), 0);
    period(10, 6'd63, -1, -1, hi, hn, ov, ps);
    check("p0_high", hi, 0);
    check("p63_duty", int'(Duty_Active), 63);
    period(10, 6'd16, -1, -1, hi, hn, ov, ps);
    check("p63_high", hi, 252);
    check("p63_ps", ps, 1);
    period(-1, 6'd0, 40, -1, hi, hn, ov, ps);
    check("drain_high", hi, 64);
    check("drain_ps", ps, 1);
    check("drain_end_ps", int'(Period_Start), 0);
    check("drain_end_busy", int'(Busy), 0);
    check("drain_end_pwm", int'(PWM_Out), 0);
    repeat (5) @(negedge sysclk);
    check("idle_busy", int'(Busy), 0);
    Enable_SW_0 = 1'b1;
    wait_start("restart_latency");
    period(-1, 6'd0, 40, 160, hi, hn, ov, ps);
    check("resume_high", hi, 64);
    check("resume_ps", int'(Period_Start), 1);
    check("resume_busy", int'(Busy), 1);
    period(10, 6'd32, -1, -1, hi, hn, ov, ps);
    check("p32_duty", int'(Duty_Active), 32);
    repeat (21) @(negedge sysclk);
    check("pre_rst_pwm", int'(PWM_Out), 1);
    Reset_n = 1'b0;
    #1;
    check("async_pwm", int'(PWM_Out), 0);
    check("async_busy", int'(Busy), 0);
    check("async_duty", int'(Duty_Active), 0);
    @(negedge sysclk);
    Reset_n = 1'b1;
    wait_start("post_rst_latency");
    check("post_rst_duty", int'(Duty_Active), 32);
    period(10, 6'd16, -1, -1, hi, hn, ov, ps);
    check("p32_high", hi, 128);
    period(-1, 6'd0, -1, -1, hi, hn, ov, ps);
    check("final_high", hi, 64);
`ifdef PWM_COMPLEMENT_EN
    check("comp_high", hn, 176);
    check("comp_overlap", ov, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
